// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 16x-oversampled UART receiver with a valid/ready byte output.
// The serial line is synchronised, the start bit is confirmed at its mid-point,
// and data and stop bits are sampled once per bit period at their centres.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_engine #(
    parameter int CLOCK_RATE         = 100000000,
    parameter int BAUD_RATE          = 9600,
    parameter int RX_OVERSAMPLE_RATE = 16,
    parameter int DATA_BITS          = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    input  logic                 rxReady,
    output logic                 rxBusy,
    output logic                 frameError,
    output logic                 overrun
);

    localparam int TICK_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE_RATE);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TC_W     = $clog2(RX_OVERSAMPLE_RATE);
    localparam int BI_W     = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TC_W-1:0]  TC_HALF  = TC_W'(RX_OVERSAMPLE_RATE / 2 - 1);
    localparam logic [TC_W-1:0]  TC_FULL  = TC_W'(RX_OVERSAMPLE_RATE - 1);
    localparam logic [BI_W-1:0]  BI_LAST  = BI_W'(DATA_BITS - 1);

    // Parameter sanity: refuse to elaborate configurations that cannot work.
    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("uart_rx_engine: CLOCK_RATE too low for BAUD_RATE*RX_OVERSAMPLE_RATE");
    end
    if ((RX_OVERSAMPLE_RATE < 4) || (RX_OVERSAMPLE_RATE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_engine: RX_OVERSAMPLE_RATE must be even and >= 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_bits
        $error("uart_rx_engine: DATA_BITS must be 5..9");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q;
    logic [1:0]           sync_q;
    logic [TC_W-1:0]      tc_q, tc_d;
    logic [BI_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver_q, deliver_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 tick;
    logic                 rx_s;

    assign tick       = (div_q == DIV_LAST);
    assign rx_s       = sync_q[1];
    assign rxData     = data_q;
    assign rxValid    = valid_q;
    assign rxBusy     = (state_q != ST_IDLE);
    assign frameError = fe_q;
    assign overrun    = ov_q;

    // Free-running oversample tick divider.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous serial line; resets to idle level.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Receiver state, counters, shift register and pending-delivery/error strobes.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= ST_IDLE;
            tc_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            deliver_q <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tc_q      <= tc_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
            fe_q      <= fe_d;
        end
    end

    // Frame FSM: every decision is taken on a tick, using the synchronised line.
    always_comb begin
        state_d   = state_q;
        tc_d      = tc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        fe_d      = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        tc_d    = '0;
                    end
                end
                ST_START: begin
                    if (tc_q == TC_HALF) begin
                        tc_d = '0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            bit_d   = '0;
                        end else begin
                            // Start bit did not survive to mid-point: treat as a glitch.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tc_d = tc_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tc_q == TC_FULL) begin
                        tc_d    = '0;
                        // LSB arrives first, so shift in at the MSB end.
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BI_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tc_d = tc_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tc_q == TC_FULL) begin
                        tc_d = '0;
                        if (rx_s) begin
                            deliver_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        tc_d = tc_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A line held low reports one framing error, then waits for idle.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tc_d    = '0;
                end
            endcase
        end
    end

    // Output holding register and handshake; a delivery wins over a same-cycle accept.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ov_d    = 1'b0;
        if (deliver_q) begin
            if (!valid_q || rxReady) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && rxReady) begin
            valid_d = 1'b0;
        end
    end

    // Output word, valid flag and overrun strobe registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: frame-level bench for uart_rx_engine at 160 clk per bit.
// Expected bytes are queued when a frame is driven and popped when the DUT
// hands a word over (rxValid && rxReady); flags are counted per test.
module tb_uart_rx_engine;

    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       rstN;
    logic       rx;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic       rxBusy;
    logic       frameError;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    logic [7:0] exp_q[$];

    uart_rx_engine #(
        .CLOCK_RATE(1536000),
        .BAUD_RATE(9600),
        .RX_OVERSAMPLE_RATE(16),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .rx(rx),
        .rxData(rxData),
        .rxValid(rxValid),
        .rxReady(rxReady),
        .rxBusy(rxBusy),
        .frameError(frameError),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clk(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    // Monitor: scoreboard pop on hand-over, handshake and flag-pulse rules.
    logic       prev_valid, prev_acc, prev_fe, prev_ov;
    logic [7:0] prev_data;
    always @(negedge clk) begin
        if (!rstN) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            prev_fe    = 1'b0;
            prev_ov    = 1'b0;
            prev_data  = '0;
        end else begin
            if (rxValid && rxReady) begin
                checks++;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept_unexpected: got %0h expected none", rxData);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rxData !== e) begin
                        errors++;
                        $display("FAIL accept_data: got %0h expected %0h", rxData, e);
                    end else begin
                        $display("ok   accept_data: %0h", rxData);
                    end
                end
            end
            if (prev_acc) begin
                checks++;
                if (rxValid !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_drop: got %0b expected 0", rxValid);
                end
            end
            if (prev_valid && !prev_acc && rxValid) begin
                checks++;
                if (rxData !== prev_data) begin
                    errors++;
                    $display("FAIL data_stable: got %0h expected %0h", rxData, prev_data);
                end
            end
            if (frameError || overrun) begin
                checks++;
                if ((frameError && overrun) || (frameError && prev_fe) || (overrun && prev_ov)) begin
                    errors++;
                    $display("FAIL flag_pulse: got fe=%0b ov=%0b expected single 1-clk pulse", frameError, overrun);
                end
            end
            if (frameError) fe_cnt++;
            if (overrun) ov_cnt++;
            prev_valid = rxValid;
            prev_acc   = rxValid && rxReady;
            prev_fe    = frameError;
            prev_ov    = overrun;
            prev_data  = rxData;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_acc;
        int         exp_fe;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int a0, f0, o0;
        logic busy_seen;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h55, 1'b0, 0, 1};
        vecs[2] = '{8'h66, 1'b1, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 0};
        vecs[5] = '{8'h80, 1'b1, 1, 0};

        rstN = 1'b0;
        rx = 1'b1;
        rxReady = 1'b0;
        wait_clk(5);
        check("reset_rxValid", rxValid, 0);
        check("reset_rxData", rxData, 0);
        check("reset_rxBusy", rxBusy, 0);
        check("reset_flags", {frameError, overrun}, 0);
        rstN = 1'b1;
        wait_clk(BIT);

        // Table: single frames with rxReady held high, good and bad stop bits.
        rxReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            wait_clk(2 * BIT);
            check($sformatf("vec%0d_accepts", i), acc_cnt - a0, vecs[i].exp_acc);
            check($sformatf("vec%0d_frameError", i), fe_cnt - f0, vecs[i].exp_fe);
            check($sformatf("vec%0d_overrun", i), ov_cnt - o0, 0);
            check($sformatf("vec%0d_queue", i), exp_q.size(), 0);
        end

        // Held word: 0x3C stays valid and stable until accepted.
        rxReady = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_clk(2000);
        check("hold_valid", rxValid, 1);
        check("hold_data", rxData, 8'h3C);
        rxReady = 1'b1;
        wait_clk(5);
        check("hold_dropped", rxValid, 0);
        check("hold_queue", exp_q.size(), 0);

        // Overrun: 0x11 then 0x22 back-to-back with nobody accepting.
        rxReady = 1'b0;
        o0 = ov_cnt; f0 = fe_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clk(2 * BIT);
        check("ovr_count", ov_cnt - o0, 1);
        check("ovr_fe", fe_cnt - f0, 0);
        check("ovr_data", rxData, 8'h11);
        check("ovr_valid", rxValid, 1);
        rxReady = 1'b1;
        wait_clk(5);
        check("ovr_queue", exp_q.size(), 0);
        check("ovr_dropped", rxValid, 0);

        // Glitch: 40-clk low pulse is rejected at mid start bit.
        a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (40) begin
            wait_clk(1);
            if (rxBusy) busy_seen = 1'b1;
        end
        rx = 1'b1;
        repeat (300) begin
            wait_clk(1);
            if (rxBusy) busy_seen = 1'b1;
        end
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_end", rxBusy, 0);
        check("glitch_accepts", acc_cnt - a0, 0);
        check("glitch_valid", rxValid, 0);
        check("glitch_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);

        // Reset mid-frame with a pending word, then a clean 0x81 frame.
        rxReady = 1'b0;
        send_frame(8'h5A, 1'b1);
        wait_clk(BIT);
        check("rst_pending_valid", rxValid, 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        wait_clk(80);
        check("rst_busy_before", rxBusy, 1);
        rstN = 1'b0;
        #1;
        check("rst_valid", rxValid, 0);
        check("rst_data", rxData, 0);
        check("rst_busy", rxBusy, 0);
        check("rst_flags", {frameError, overrun}, 0);
        wait_clk(5);
        rstN = 1'b1;
        rxReady = 1'b1;
        wait_clk(BIT);
        check("rst_idle_valid", rxValid, 0);
        a0 = acc_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_clk(2 * BIT);
        check("rst_next_accepts", acc_cnt - a0, 1);
        check("rst_next_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
